// File: rtl/conv_block_sequencer_if.sv
// ============================================================================
// conv_block_sequencer_if : control/MCU <-> sequencer handshake and BRAM bus
// rev 1.0
// ============================================================================
`default_nettype none

interface conv_block_sequencer_if #(
  parameter int NB_ADDRESS = 10
);
  logic                  start;
  logic [NB_ADDRESS-1:0] img_length;
  logic [NB_ADDRESS-1:0] num_blocks;
  logic                  hold;
  logic                  block_ack;
  logic [NB_ADDRESS-1:0] read_add;
  logic [NB_ADDRESS-1:0] write_add;
  logic                  conv_valid;
  logic                  wr_en;
  logic                  conv_clr;
  logic                  change_block;
  logic                  busy;
  logic                  eop;
  logic                  cfg_err;
  logic [NB_ADDRESS-1:0] block_cnt;

  modport master (
    output start, img_length, num_blocks, hold, block_ack,
    input  read_add, write_add, conv_valid, wr_en, conv_clr,
           change_block, busy, eop, cfg_err, block_cnt
  );

  modport slave (
    input  start, img_length, num_blocks, hold, block_ack,
    output read_add, write_add, conv_valid, wr_en, conv_clr,
           change_block, busy, eop, cfg_err, block_cnt
  );
endinterface

`default_nettype wire

// File: rtl/conv_block_sequencer.sv
// ============================================================================
// conv_block_sequencer : per-block read walk, delayed write-back, MCU handshake
// rev 1.0
// ============================================================================
`default_nettype none

module conv_block_sequencer #(
  parameter int NB_ADDRESS = 10,
  parameter int CONV_LAT   = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  conv_block_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    DRAIN    = 3'd2,
    BLK_WAIT = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [NB_ADDRESS-1:0] ONE        = NB_ADDRESS'(1);
  localparam logic [NB_ADDRESS-1:0] MIN_LEN    = NB_ADDRESS'(3);
  localparam logic [2:0]            DRAIN_LAST = 3'(CONV_LAT);

  state_t                state;
  logic [NB_ADDRESS-1:0] len;
  logic [NB_ADDRESS-1:0] nblk;
  logic [NB_ADDRESS-1:0] rd_add;
  logic [NB_ADDRESS-1:0] blk_cnt;
  logic [2:0]            drain_cnt;
  logic [CONV_LAT:0]     v_pipe;
  logic [NB_ADDRESS-1:0] a_pipe [CONV_LAT+1];
  logic                  conv_clr;
  logic                  change_block;
  logic                  eop;
  logic                  cfg_err;
  logic                  frz;
  logic                  rd_issue;

  // Hold only freezes the datapath while a block is in flight.
  assign frz      = bus.hold && ((state == RUN) || (state == DRAIN));
  assign rd_issue = (state == RUN) && !bus.hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len          <= '0;
      nblk         <= '0;
      rd_add       <= '0;
      blk_cnt      <= '0;
      drain_cnt    <= '0;
      v_pipe       <= '0;
      conv_clr     <= 1'b0;
      change_block <= 1'b0;
      eop          <= 1'b0;
      cfg_err      <= 1'b0;
      for (int i = 0; i <= CONV_LAT; i++) a_pipe[i] <= '0;
    end else begin
      conv_clr <= 1'b0;
      eop      <= 1'b0;
      cfg_err  <= 1'b0;

      if (!frz) begin
        v_pipe    <= {v_pipe[CONV_LAT-1:0], rd_issue};
        a_pipe[0] <= rd_add;
        for (int i = 1; i <= CONV_LAT; i++) a_pipe[i] <= a_pipe[i-1];
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            if ((bus.img_length < MIN_LEN) || (bus.num_blocks == '0)) begin
              cfg_err <= 1'b1;
            end else begin
              len      <= bus.img_length;
              nblk     <= bus.num_blocks;
              blk_cnt  <= '0;
              rd_add   <= '0;
              conv_clr <= 1'b1;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (!bus.hold) begin
            if (rd_add == len - ONE) begin
              rd_add    <= '0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              rd_add <= rd_add + ONE;
            end
          end
        end
        DRAIN: begin
          // Wait out BRAM latency plus convolutor latency so the last write lands.
          if (!bus.hold) begin
            if (drain_cnt == DRAIN_LAST) begin
              if (blk_cnt == nblk - ONE) begin
                eop   <= 1'b1;
                state <= DONE;
              end else begin
                change_block <= 1'b1;
                state        <= BLK_WAIT;
              end
            end else begin
              drain_cnt <= drain_cnt + 3'd1;
            end
          end
        end
        BLK_WAIT: begin
          if (bus.block_ack) begin
            blk_cnt      <= blk_cnt + ONE;
            conv_clr     <= 1'b1;
            change_block <= 1'b0;
            rd_add       <= '0;
            state        <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.read_add     = rd_add;
  assign bus.write_add    = a_pipe[CONV_LAT];
  assign bus.conv_valid   = v_pipe[0] && !frz;
  assign bus.wr_en        = v_pipe[CONV_LAT] && !frz;
  assign bus.conv_clr     = conv_clr;
  assign bus.change_block = change_block;
  assign bus.busy         = (state != IDLE);
  assign bus.eop          = eop;
  assign bus.cfg_err      = cfg_err;
  assign bus.block_cnt    = blk_cnt;

endmodule

`default_nettype wire

// File: doc/conv_block_sequencer.md
Name: conv_block_sequencer

Overview:
Run-time sequencer for the 3-line-buffer convolution datapath: once the control block issues RUN, it walks the BRAM read address over one column block and drives the convolutor valid. It generates the write-back address and enable with a matching pipeline delay, and handshakes with the MCU for the next block between column blocks. At frame end it emits a one-cycle end-of-processing pulse. It replaces the address/valid duties of the current free-running FSM and adds hold, block handshake and config checking.

Parameters:
NB_ADDRESS, 10, width of BRAM read/write addresses, image length and block count.
CONV_LAT, 2, convolutor latency in cycles from i_valid-qualified input to valid o_data; legal range 1..7.

Ports:
i_CLK  in  1  system clock, all logic on rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  RUN request pulse from control block; sampled only in IDLE
i_img_length  in  NB_ADDRESS  rows per column block (L); sampled on accepted start
i_num_blocks  in  NB_ADDRESS  column blocks per frame (N); sampled on accepted start
i_hold  in  1  freeze request (MCU back-pressure)
i_block_ack  in  1  MCU has reloaded buffers for the next block
o_readAdd  out  NB_ADDRESS  BRAM read address, shared by all three memories
o_writeAdd  out  NB_ADDRESS  BRAM write address for memory 0 result write-back
o_conv_valid  out  1  convolutor i_valid
o_wr_en  out  1  write enable for memory 0 write-back
o_conv_clr  out  1  one-cycle flush of convolutor taps at each block start
o_change_block  out  1  level request for next block, held until ack
o_busy  out  1  high in any state except IDLE
o_EoP  out  1  one-cycle end-of-processing pulse
o_cfg_err  out  1  one-cycle pulse on rejected start
o_block_cnt  out  NB_ADDRESS  index of current block

Behaviour:
- Reset (async, i_reset=0): state IDLE; all outputs 0; address counter, block counter and delay lines cleared. Reset mid-run aborts with no EoP.
- States: IDLE, RUN, DRAIN, BLK_WAIT, DONE.
- IDLE:
  - Start with L<3 or N=0: pulse o_cfg_err for one cycle and stay in IDLE.
  - Otherwise: latch L and N, clear block_cnt, pulse o_conv_clr for one cycle, and go to RUN.
- RUN:
  - o_readAdd counts 0..L-1, one per non-held cycle, with internal rd_issue=1.
  - After issuing address L-1, go to DRAIN.
- Delay line (depth 1+CONV_LAT):
  - o_conv_valid = rd_issue delayed 1 cycle (BRAM read latency).
  - o_wr_en = rd_issue delayed 1+CONV_LAT.
  - o_writeAdd = o_readAdd delayed 1+CONV_LAT.
  - A read issued at cycle t is therefore written back at cycle t+1+CONV_LAT.
- DRAIN:
  - Lasts exactly 1+CONV_LAT non-held cycles, with no new reads.
  - Then, if block_cnt==N-1, go to DONE; else go to BLK_WAIT.
- BLK_WAIT:
  - o_change_block=1; o_readAdd holds at 0.
  - On i_block_ack=1 (same-cycle acceptance): block_cnt+1, pulse o_conv_clr for one cycle, go to RUN at address 0.
  - Ack outside BLK_WAIT is ignored.
- DONE: o_EoP=1 for one cycle, then IDLE. o_busy falls on entry to IDLE.
- Hold:
  - While i_hold=1 in RUN or DRAIN: address counter, drain counter and delay line freeze, and o_conv_valid and o_wr_en are forced to 0.
  - On release, the sequence resumes exactly where it stopped; no read or write is lost or duplicated.
  - Hold has no effect in IDLE, BLK_WAIT or DONE.
- Start while o_busy=1 is ignored. Input changes to i_img_length/i_num_blocks mid-run have no effect.
- Counters never wrap: L up to 2^NB_ADDRESS-1; the read counter stops at L-1.
- Reads issued per block = L; writes per block = L; total writes per frame = L*N.

Test Plan:
- Basic, L=4, N=1, CONV_LAT=2, start at cycle 0 -> reads addr 0..3 at cycles 1-4; o_conv_valid cycles 2-5; o_wr_en cycles 4-7 with o_writeAdd 0..3; o_EoP cycle 8 only; o_busy cycles 1-8.
- Multi-block, L=5, N=3, ack 4 cycles after each o_change_block rise -> o_change_block asserted twice; o_conv_clr 3 pulses; 15 writes total; o_block_cnt 0→1→2; one o_EoP after block 2 drain.
- Hold, L=6, N=1, i_hold=1 for 3 cycles after address 2 is issued -> no valid/wr_en during hold; addresses continue at 3; wr_en count 6; EoP delayed by exactly 3 cycles versus the no-hold run.
- Config errors: start with L=2 -> o_cfg_err one cycle, o_busy stays 0. Start with N=0 -> same. Start with L=3, N=1 -> normal run with 3 writes.
- Async reset asserted mid-DRAIN -> all outputs 0 immediately, no o_EoP. After release, a new start (L=4, N=1) repeats the basic timing.
- Spurious inputs: i_start pulsed during RUN and i_block_ack pulsed during RUN -> both ignored, with cycle-identical outputs to the basic scenario.
